mmio_fabric: RTL
================

MMIO_FABRIC -- requirements
Module: mmio_fabric

Interface
REQ-001 SHALL have parameter DATA_W, default 16, data bus width.
REQ-002 SHALL have parameter ADDR_W, default 16, address bus width.
REQ-003 SHALL have parameter N_SLV, default 3, slave count, legal 1..8.
REQ-004 SHALL have parameter SLV_BASE, default {16'h6000,16'h4000,16'h0000}, packed N_SLV*ADDR_W match values, slave 0 in LSBs.
REQ-005 SHALL have parameter SLV_MASK, default {16'hFFFF,16'hE000,16'hC000}, packed N_SLV*ADDR_W compare masks.
REQ-006 SHALL have parameter TIMEOUT, default 15, max ACCESS cycles before error; 0 disables timeout.
REQ-007 SHALL have parameter ERR_DATA, default 0, m_rdata value on error.
REQ-008 Ports: clk  in  1  single clock, all logic on rising edge.
REQ-009 Ports: reset  in  1  asynchronous, active-low reset.
REQ-010 Ports: m_req  in  1  master access request; m_we  in  1  1=write; m_addr  in  ADDR_W; m_wdata  in  DATA_W.
REQ-011 Ports: m_rdata  out  DATA_W  read data; m_ready  out  1  one-cycle completion pulse; m_err  out  1  error, valid with m_ready.
REQ-012 Ports: s_sel  out  N_SLV  one-hot slave select; s_we  out  1; s_addr  out  ADDR_W; s_wdata  out  DATA_W.
REQ-013 Ports: s_rdata  in  N_SLV*DATA_W  packed slave read data; s_ready  in  N_SLV  per-slave completion.
REQ-014 Ports: err_count  out  8  saturating error counter.

Function
REQ-015 Slave i hits when (addr & SLV_MASK[i]) == SLV_BASE[i]; multiple hits resolve to lowest index; no hit = unmapped.
REQ-016 FSM states IDLE, ACCESS, RESP; only IDLE samples m_req.
REQ-017 IDLE, m_req=1 at edge k: latch m_addr, m_we, m_wdata, decoded index; mapped -> ACCESS, unmapped -> RESP with error.
REQ-018 ACCESS: s_sel one-hot for latched slave, s_we/s_addr/s_wdata driven from latched values, stable for whole ACCESS.
REQ-019 ACCESS, s_ready[sel]=1 at an edge: capture s_rdata slice of selected slave (reads), -> RESP, no error; s_ready of unselected slaves ignored.
REQ-020 ACCESS, cycle counter reaching TIMEOUT without s_ready (TIMEOUT>0): -> RESP with error; s_sel deasserts on that edge.
REQ-021 RESP: m_ready=1 exactly one cycle, m_err valid, then -> IDLE unconditionally.
REQ-022 m_rdata holds last captured value until next response; on error (read or write) loads ERR_DATA; successful write leaves m_rdata unchanged.
REQ-023 Latency: mapped slave with s_ready=1 in first ACCESS cycle -> m_ready in cycle k+2; unmapped -> m_ready in cycle k+1.
REQ-024 m_req held high through RESP starts next transaction at first IDLE edge (back-to-back, one idle cycle between accesses); master deasserts m_req during m_ready cycle to stop.
REQ-025 m_addr/m_wdata changes outside IDLE sampling edge SHALL have no effect.
REQ-026 s_sel=0 and s_we=0 in IDLE and RESP.
REQ-027 err_count increments by 1 per RESP with error, saturates at 255, never wraps.

Reset
REQ-028 reset low: immediately (asynchronously) state=IDLE, s_sel=0, s_we=0, s_addr=0, s_wdata=0, m_ready=0, m_err=0, m_rdata=0, err_count=0, timeout counter=0.
REQ-029 reset asserted mid-ACCESS aborts transaction with no m_ready pulse; first m_req sampled at first rising edge after release.

Verification
REQ-030 Read 0x0010, slave0 s_ready=1 immediately, s_rdata0=16'hBEEF -> s_sel=3'b001 one cycle, m_ready at k+2, m_rdata=16'hBEEF, m_err=0.
REQ-031 Write 0x4005 data 16'h1234, slave1 s_ready after 3 cycles -> s_sel=3'b010, s_we=1, s_wdata=16'h1234 for 3 cycles, m_ready with m_err=0, m_rdata unchanged.
REQ-032 Read 0x7000 (unmapped) -> no s_sel, m_ready at k+1, m_err=1, m_rdata=0, err_count=1.
REQ-033 Read 0x6000, slave2 never ready -> s_sel=3'b100 for 15 cycles, then m_ready with m_err=1, m_rdata=0.
REQ-034 256 unmapped accesses -> err_count=255, stays 255.
REQ-035 reset low during ACCESS to slave1 -> all outputs 0 same cycle, no m_ready; after release, read 0x0000 completes normally.

Source files
------------

// File: rtl/mmio_fabric.sv
// Single-master MMIO fabric: decodes a master access to one of N_SLV slaves, holds the
// slave-side request stable until that slave completes or the access times out.
module mmio_fabric #(
  parameter int unsigned               DATA_W   = 16,
  parameter int unsigned               ADDR_W   = 16,
  parameter int unsigned               N_SLV    = 3,
  parameter logic [N_SLV*ADDR_W-1:0]   SLV_BASE = {16'h6000, 16'h4000, 16'h0000},
  parameter logic [N_SLV*ADDR_W-1:0]   SLV_MASK = {16'hFFFF, 16'hE000, 16'hC000},
  parameter int unsigned               TIMEOUT  = 15,
  parameter logic [DATA_W-1:0]         ERR_DATA = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      m_req,
  input  logic                      m_we,
  input  logic [ADDR_W-1:0]         m_addr,
  input  logic [DATA_W-1:0]         m_wdata,
  output logic [DATA_W-1:0]         m_rdata,
  output logic                      m_ready,
  output logic                      m_err,
  output logic [N_SLV-1:0]          s_sel,
  output logic                      s_we,
  output logic [ADDR_W-1:0]         s_addr,
  output logic [DATA_W-1:0]         s_wdata,
  input  logic [N_SLV*DATA_W-1:0]   s_rdata,
  input  logic [N_SLV-1:0]          s_ready,
  output logic [7:0]                err_count
);

  localparam int unsigned IDX_W = (N_SLV > 1) ? $clog2(N_SLV) : 1;
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} stateT;

  stateT              stateQ, stateD;
  logic [ADDR_W-1:0]  addrQ, addrD;
  logic [DATA_W-1:0]  wdataQ, wdataD;
  logic               weQ, weD;
  logic [IDX_W-1:0]   selQ, selD;
  logic [CNT_W-1:0]   cntQ, cntD;
  logic [DATA_W-1:0]  rdataQ, rdataD;
  logic               errQ, errD;
  logic [7:0]         errCntQ, errCntD;

  logic               hit;
  logic [IDX_W-1:0]   hitIdx;
  logic [DATA_W-1:0]  selRdata;
  logic               selReady;
  logic [N_SLV-1:0]   selOneHot;
  logic               setErr;

  // Descending scan so the lowest matching index is the one that sticks.
  always_comb begin
    hit    = 1'b0;
    hitIdx = '0;
    for (int i = N_SLV - 1; i >= 0; i--) begin
      if ((m_addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
        hit    = 1'b1;
        hitIdx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    selRdata  = '0;
    selReady  = 1'b0;
    selOneHot = '0;
    for (int i = 0; i < N_SLV; i++) begin
      if (selQ == IDX_W'(i)) begin
        selRdata     = s_rdata[i*DATA_W +: DATA_W];
        selReady     = s_ready[i];
        selOneHot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    stateD  = stateQ;
    addrD   = addrQ;
    wdataD  = wdataQ;
    weD     = weQ;
    selD    = selQ;
    cntD    = cntQ;
    rdataD  = rdataQ;
    errD    = errQ;
    errCntD = errCntQ;
    setErr  = 1'b0;
    unique case (stateQ)
      StIdle: begin
        if (m_req) begin
          addrD  = m_addr;
          wdataD = m_wdata;
          weD    = m_we;
          selD   = hitIdx;
          cntD   = '0;
          if (hit) begin
            stateD = StAccess;
          end else begin
            stateD = StResp;
            setErr = 1'b1;
          end
        end
      end
      StAccess: begin
        if (selReady) begin
          stateD = StResp;
          errD   = 1'b0;
          if (!weQ) rdataD = selRdata;
        end else if (TIMEOUT > 0 && cntQ == CNT_LAST) begin
          stateD = StResp;
          setErr = 1'b1;
        end else if (TIMEOUT > 0) begin
          cntD = cntQ + 1'b1;
        end
      end
      StResp: begin
        stateD = StIdle;
        cntD   = '0;
      end
      default: stateD = StIdle;
    endcase
    if (setErr) begin
      errD   = 1'b1;
      rdataD = ERR_DATA;
      if (errCntQ != 8'hFF) errCntD = errCntQ + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateQ  <= StIdle;
      addrQ   <= '0;
      wdataQ  <= '0;
      weQ     <= 1'b0;
      selQ    <= '0;
      cntQ    <= '0;
      rdataQ  <= '0;
      errQ    <= 1'b0;
      errCntQ <= '0;
    end else begin
      stateQ  <= stateD;
      addrQ   <= addrD;
      wdataQ  <= wdataD;
      weQ     <= weD;
      selQ    <= selD;
      cntQ    <= cntD;
      rdataQ  <= rdataD;
      errQ    <= errD;
      errCntQ <= errCntD;
    end
  end

  assign s_sel     = (stateQ == StAccess) ? selOneHot : '0;
  assign s_we      = (stateQ == StAccess) && weQ;
  assign s_addr    = addrQ;
  assign s_wdata   = wdataQ;
  assign m_ready   = (stateQ == StResp);
  assign m_err     = (stateQ == StResp) && errQ;
  assign m_rdata   = rdataQ;
  assign err_count = errCntQ;

endmodule
